// File: rtl/forth_alu_seq.sv
// Registered FORTH ALU: logic/add/sub/shift/compare finish in one cycle,
// MUL (shift-add) and UDIV/UMOD (restoring division) iterate over WIDTH cycles.
module forth_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       opcode,
   input  logic [WIDTH-1:0] oper0,
   input  logic [WIDTH-1:0] oper1,
   input  logic             oe,
   output logic [WIDTH-1:0] data_bus,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v
);

   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_INV  = 8'h04;
   localparam logic [7:0] OP_SHL  = 8'h05;
   localparam logic [7:0] OP_SHR  = 8'h06;
   localparam logic [7:0] OP_ADD  = 8'h07;
   localparam logic [7:0] OP_SUB  = 8'h08;
   localparam logic [7:0] OP_NEG  = 8'h09;
   localparam logic [7:0] OP_ZEQ  = 8'h0A;
   localparam logic [7:0] OP_LT   = 8'h0B;
   localparam logic [7:0] OP_ULT  = 8'h0C;
   localparam logic [7:0] OP_MUL  = 8'h0D;
   localparam logic [7:0] OP_UDIV = 8'h0E;
   localparam logic [7:0] OP_UMOD = 8'h0F;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [7:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
   logic             busy_q, done_q, err_q, z_q, n_q, c_q, v_q;

   logic [WIDTH:0]   sum_w, diff_w;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c, sc_v, sc_err, sc_illegal, start_iter;

   always_comb begin
      sum_w      = {1'b0, oper0} + {1'b0, oper1};
      diff_w     = {1'b0, oper0} - {1'b0, oper1};
      sc_res     = '0;
      sc_c       = 1'b0;
      sc_v       = 1'b0;
      sc_err     = 1'b0;
      sc_illegal = 1'b0;
      start_iter = 1'b0;
      case (opcode)
         OP_AND: sc_res = oper0 & oper1;
         OP_OR:  sc_res = oper0 | oper1;
         OP_XOR: sc_res = oper0 ^ oper1;
         OP_INV: sc_res = ~oper0;
         OP_SHL: begin
            sc_res = {oper0[WIDTH-2:0], 1'b0};
            sc_c   = oper0[WIDTH-1];
         end
         OP_SHR: begin
            sc_res = {oper0[WIDTH-1], oper0[WIDTH-1:1]};
            sc_c   = oper0[0];
         end
         OP_ADD: begin
            sc_res = sum_w[WIDTH-1:0];
            sc_c   = sum_w[WIDTH];
            sc_v   = (oper0[WIDTH-1] == oper1[WIDTH-1]) && (sum_w[WIDTH-1] != oper0[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff_w[WIDTH-1:0];
            sc_c   = diff_w[WIDTH];
            sc_v   = (oper0[WIDTH-1] != oper1[WIDTH-1]) && (diff_w[WIDTH-1] != oper0[WIDTH-1]);
         end
         OP_NEG: sc_res = '0 - oper0;
         OP_ZEQ: sc_res = {WIDTH{oper0 == '0}};
         OP_LT:  sc_res = {WIDTH{$signed(oper0) < $signed(oper1)}};
         OP_ULT: sc_res = {WIDTH{diff_w[WIDTH]}};
         OP_MUL: start_iter = 1'b1;
         OP_UDIV, OP_UMOD: begin
            // a zero divisor resolves immediately instead of entering RUN
            if (oper1 == '0) begin
               sc_err = 1'b1;
               sc_res = (opcode == OP_UDIV) ? '1 : oper0;
            end else begin
               start_iter = 1'b1;
            end
         end
         default: begin
            sc_illegal = 1'b1;
            sc_err     = 1'b1;
         end
      endcase
   end

   // one iteration: a_q is multiplicand or dividend/quotient, acc_q the product or remainder
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] a_d, b_d, acc_d, it_res;

   always_comb begin
      rem_sh = {acc_q, a_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, b_q};
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      if (op_q == OP_MUL) begin
         acc_d = b_q[0] ? acc_q + a_q : acc_q;
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
      end else if (!trial[WIDTH]) begin
         acc_d = trial[WIDTH-1:0];
         a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_d = rem_sh[WIDTH-1:0];
         a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
      it_res = (op_q == OP_UDIV) ? a_d : acc_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (start_iter) begin
                     op_q    <= opcode;
                     a_q     <= oper0;
                     b_q     <= oper1;
                     acc_q   <= '0;
                     cnt_q   <= CW'(WIDTH);
                     busy_q  <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     result_q <= sc_res;
                     z_q      <= !sc_illegal && (sc_res == '0);
                     n_q      <= sc_res[WIDTH-1];
                     c_q      <= sc_c;
                     v_q      <= sc_v;
                     err_q    <= sc_err;
                     done_q   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               a_q   <= a_d;
               b_q   <= b_d;
               acc_q <= acc_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  result_q <= it_res;
                  z_q      <= (it_res == '0);
                  n_q      <= it_res[WIDTH-1];
                  c_q      <= 1'b0;
                  v_q      <= 1'b0;
                  err_q    <= 1'b0;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign data_bus = oe ? result_q : 'z;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign flag_z   = z_q;
   assign flag_n   = n_q;
   assign flag_c   = c_q;
   assign flag_v   = v_q;

endmodule
